// File: rtl/regfile_commit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_commit_arbiter_pkg
//   Shared types and constants for the register-file commit path.
//   - XLEN / COMMIT_PORTS / LOG2_COMMIT_PORTS : default datapath geometry
//   - reg_addr_t    : architectural register index (x0..x31)
//   - wb_req_t      : one unit's writeback request (valid, rd, data)
//   - wb_port_sel_t : write-port index as reported on wb_port
//   - wrap_idx()    : single-step modulo used for round-robin index math
// -----------------------------------------------------------------------------
package regfile_commit_arbiter_pkg;

  localparam int XLEN              = 32;
  localparam int COMMIT_PORTS      = 2;
  localparam int LOG2_COMMIT_PORTS = 1;
  localparam int REG_ADDR_W        = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic            valid;
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef logic [LOG2_COMMIT_PORTS-1:0] wb_port_sel_t;

  // idx is always < 2*n at the call sites, so one conditional subtract
  // is a complete modulo and avoids a divider.
  function automatic int unsigned wrap_idx(input int unsigned idx,
                                           input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/regfile_commit_arbiter_rr_scan.sv
// -----------------------------------------------------------------------------
// regfile_commit_arbiter_rr_scan
//   Purely combinational grant scan over requests that have already been
//   rotated so that slot 0 is the current round-robin head.
//   Ports:
//     rot_valid_i : per-slot request valid
//     rot_rd_i    : per-slot destination register, 5 bits each
//     rot_grant_o : per-slot grant (includes rd==0 requests, which take no port)
//     rot_write_o : per-slot "granted and occupies a write port"
//     rot_port_o  : per-slot write-port index (meaningful when rot_write_o set)
// -----------------------------------------------------------------------------
module regfile_commit_arbiter_rr_scan
  import regfile_commit_arbiter_pkg::*;
#(
  parameter int NUM_UNITS        = 4,
  parameter int WRITE_PORTS      = COMMIT_PORTS,
  parameter int LOG2_WRITE_PORTS = LOG2_COMMIT_PORTS
) (
  input  logic [NUM_UNITS-1:0]                  rot_valid_i,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0]       rot_rd_i,
  output logic [NUM_UNITS-1:0]                  rot_grant_o,
  output logic [NUM_UNITS-1:0]                  rot_write_o,
  output logic [NUM_UNITS*LOG2_WRITE_PORTS-1:0] rot_port_o
);

  reg_addr_t rd_slot [NUM_UNITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unpack
      assign rd_slot[gi] = rot_rd_i[gi*REG_ADDR_W +: REG_ADDR_W];
    end
  endgenerate

  // Walk the slots in priority order. A nonzero rd needs a free port and
  // must not collide with any rd already granted earlier in this same scan;
  // the downstream XOR bank-select update breaks if one rd retires twice in
  // a single cycle. Writes to x0 are simply absorbed.
  always_comb begin
    logic [NUM_UNITS-1:0]                  grant_v;
    logic [NUM_UNITS-1:0]                  write_v;
    logic [NUM_UNITS*LOG2_WRITE_PORTS-1:0] port_v;
    int                                    used;
    logic                                  clash;

    grant_v = '0;
    write_v = '0;
    port_v  = '0;
    used    = 0;

    for (int i = 0; i < NUM_UNITS; i++) begin
      clash = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (write_v[j] && (rd_slot[j] == rd_slot[i])) begin
          clash = 1'b1;
        end
      end

      if (rot_valid_i[i]) begin
        if (rd_slot[i] == '0) begin
          grant_v[i] = 1'b1;
        end else if ((used < WRITE_PORTS) && !clash) begin
          grant_v[i] = 1'b1;
          write_v[i] = 1'b1;
          // Ports are handed out densely from 0 in grant order.
          port_v[i*LOG2_WRITE_PORTS +: LOG2_WRITE_PORTS] = LOG2_WRITE_PORTS'(used);
          used = used + 1;
        end
      end
    end

    rot_grant_o = grant_v;
    rot_write_o = write_v;
    rot_port_o  = port_v;
  end

endmodule

// File: rtl/regfile_commit_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_commit_arbiter
//   Collects results from NUM_UNITS execution units over valid/ack and issues
//   up to WRITE_PORTS register-file writes per cycle, round-robin fair across
//   units, never retiring the same rd on two ports in one cycle.
//   Ports:
//     clk_i          : clock, all state on posedge
//     rst_i          : synchronous active-high reset
//     unit_valid_i   : per-unit result pending (rd/data held until acked)
//     unit_rd_i      : per-unit destination register, 5 bits each
//     unit_data_i    : per-unit result, XLEN bits each
//     unit_ack_o     : combinational accept, forced low during reset
//     rd_addr_o      : registered write address per port
//     rd_data_o      : registered write data per port
//     rd_retired_o   : registered write enable per port
//     wb_port_o      : registered port index of each unit's most recent write
// -----------------------------------------------------------------------------
module regfile_commit_arbiter
  import regfile_commit_arbiter_pkg::*;
#(
  parameter int NUM_UNITS        = 4,
  parameter int WRITE_PORTS      = COMMIT_PORTS,
  parameter int LOG2_WRITE_PORTS = LOG2_COMMIT_PORTS,
  parameter int XLEN             = regfile_commit_arbiter_pkg::XLEN
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_UNITS-1:0]                  unit_valid_i,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0]       unit_rd_i,
  input  logic [NUM_UNITS*XLEN-1:0]             unit_data_i,
  output logic [NUM_UNITS-1:0]                  unit_ack_o,
  output logic [WRITE_PORTS*REG_ADDR_W-1:0]     rd_addr_o,
  output logic [WRITE_PORTS*XLEN-1:0]           rd_data_o,
  output logic [WRITE_PORTS-1:0]                rd_retired_o,
  output logic [NUM_UNITS*LOG2_WRITE_PORTS-1:0] wb_port_o
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int PW    = LOG2_WRITE_PORTS;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]                  rr_ptr_q,     rr_ptr_d;
  logic [WRITE_PORTS-1:0]            rd_retired_q, rd_retired_d;
  logic [WRITE_PORTS*REG_ADDR_W-1:0] rd_addr_q,    rd_addr_d;
  logic [WRITE_PORTS*XLEN-1:0]       rd_data_q,    rd_data_d;
  logic [NUM_UNITS*PW-1:0]           wb_port_q,    wb_port_d;

  // ---------------------------------------------------------------------------
  // Rotation: slot k of the scan is unit (rr_ptr + k) mod NUM_UNITS.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]                  slot_unit [NUM_UNITS];
  logic [NUM_UNITS-1:0]              rot_valid;
  logic [NUM_UNITS*REG_ADDR_W-1:0]   rot_rd;
  logic [NUM_UNITS-1:0]              rot_grant;
  logic [NUM_UNITS-1:0]              rot_write;
  logic [NUM_UNITS*PW-1:0]           rot_port;
  logic [NUM_UNITS-1:0]              unit_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_rotate
      assign slot_unit[gi] =
        PTR_W'(wrap_idx(int'(rr_ptr_q) + gi, NUM_UNITS));
      assign rot_valid[gi] = unit_valid_i[slot_unit[gi]];
      assign rot_rd[gi*REG_ADDR_W +: REG_ADDR_W] =
        unit_rd_i[slot_unit[gi]*REG_ADDR_W +: REG_ADDR_W];
    end
  endgenerate

  regfile_commit_arbiter_rr_scan #(
    .NUM_UNITS        (NUM_UNITS),
    .WRITE_PORTS      (WRITE_PORTS),
    .LOG2_WRITE_PORTS (LOG2_WRITE_PORTS)
  ) u_scan (
    .rot_valid_i (rot_valid),
    .rot_rd_i    (rot_rd),
    .rot_grant_o (rot_grant),
    .rot_write_o (rot_write),
    .rot_port_o  (rot_port)
  );

  // ---------------------------------------------------------------------------
  // Un-rotate grants back to unit order.
  // ---------------------------------------------------------------------------
  always_comb begin
    unit_grant = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (rot_grant[i]) begin
        unit_grant[slot_unit[i]] = 1'b1;
      end
    end
  end

  // Acks are suppressed in reset so anything granted in that cycle is still
  // held by its unit and gets re-arbitrated after release.
  assign unit_ack_o = rst_i ? '0 : unit_grant;

  // ---------------------------------------------------------------------------
  // Next-state: output stage, wb_port tracking and round-robin pointer.
  // Unused ports keep their previous address/data; only the enable drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    int               p;
    logic             any_grant;
    logic [PTR_W-1:0] last_unit;

    rd_retired_d = '0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    wb_port_d    = wb_port_q;
    any_grant    = 1'b0;
    last_unit    = '0;
    p            = 0;

    for (int i = 0; i < NUM_UNITS; i++) begin
      if (rot_write[i]) begin
        p = int'(rot_port[i*PW +: PW]);
        rd_retired_d[p] = 1'b1;
        rd_addr_d[p*REG_ADDR_W +: REG_ADDR_W] = rot_rd[i*REG_ADDR_W +: REG_ADDR_W];
        rd_data_d[p*XLEN +: XLEN] = unit_data_i[slot_unit[i]*XLEN +: XLEN];
        wb_port_d[slot_unit[i]*PW +: PW] = rot_port[i*PW +: PW];
      end
      // Slots are in priority order, so the last hit is the furthest grant
      // from the head; the next scan starts just past it.
      if (rot_grant[i]) begin
        any_grant = 1'b1;
        last_unit = slot_unit[i];
      end
    end

    rr_ptr_d = any_grant
             ? PTR_W'(wrap_idx(int'(last_unit) + 1, NUM_UNITS))
             : rr_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      rd_retired_q <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      wb_port_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rd_retired_q <= rd_retired_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      wb_port_q    <= wb_port_d;
    end
  end

  assign rd_retired_o = rd_retired_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign wb_port_o    = wb_port_q;

endmodule

// File: tb/tb_regfile_commit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_commit_arbiter
//   Table of per-cycle vectors with expected acks and expected write-port
//   results; output expectations are queued when a vector is driven and
//   compared one cycle later when the registered stage shows them.
// -----------------------------------------------------------------------------
module tb_regfile_commit_arbiter;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int PW = 1;
  localparam int XW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      unit_valid;
  logic [N*5-1:0]    unit_rd;
  logic [N*XW-1:0]   unit_data;
  logic [N-1:0]      unit_ack;
  logic [W*5-1:0]    rd_addr;
  logic [W*XW-1:0]   rd_data;
  logic [W-1:0]      rd_retired;
  logic [N*PW-1:0]   wb_port;

  always #5 clk = ~clk;

  regfile_commit_arbiter #(
    .NUM_UNITS        (N),
    .WRITE_PORTS      (W),
    .LOG2_WRITE_PORTS (PW),
    .XLEN             (XW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .unit_valid_i (unit_valid),
    .unit_rd_i    (unit_rd),
    .unit_data_i  (unit_data),
    .unit_ack_o   (unit_ack),
    .rd_addr_o    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_retired_o (rd_retired),
    .wb_port_o    (wb_port)
  );

  typedef struct packed {
    logic            rst;
    logic [3:0]      valid;
    logic [3:0][4:0] rd;
    logic [3:0]      ack;
    logic [1:0]      ret;
    logic [1:0][4:0] addr;
    logic [1:0][1:0] src;
    logic [3:0]      wb;
  } vec_t;

  typedef struct {
    logic [1:0]       ret;
    logic [1:0][4:0]  addr;
    logic [1:0][31:0] data;
    logic [3:0]       wb;
    logic             chk_all;
    string            name;
  } out_t;

  out_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  vec_t table_v [16];

  // Result value carries its producer and rd so a wrong routing is visible.
  function automatic logic [31:0] mkdata(input logic [4:0] rd, input int unit);
    return {8'hA5, 3'b000, rd, 16'(unit)};
  endfunction

  function automatic vec_t mk(input logic [3:0] valid,
                              input logic [4:0] r3, input logic [4:0] r2,
                              input logic [4:0] r1, input logic [4:0] r0,
                              input logic [3:0] ack, input logic [1:0] ret,
                              input logic [4:0] a1, input logic [4:0] a0,
                              input logic [1:0] s1, input logic [1:0] s0,
                              input logic [3:0] wb);
    vec_t v;
    v.rst   = 1'b0;
    v.valid = valid;
    v.rd    = {r3, r2, r1, r0};
    v.ack   = ack;
    v.ret   = ret;
    v.addr  = {a1, a0};
    v.src   = {s1, s0};
    v.wb    = wb;
    return v;
  endfunction

  task automatic check_out();
    out_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checks++;
    if (rd_retired !== e.ret) begin
      errors++;
      $display("FAIL %s rd_retired: got %b want %b", e.name, rd_retired, e.ret);
    end
    checks++;
    if (wb_port !== e.wb) begin
      errors++;
      $display("FAIL %s wb_port: got %b want %b", e.name, wb_port, e.wb);
    end
    for (int p = 0; p < W; p++) begin
      if (e.ret[p] || e.chk_all) begin
        checks++;
        if (rd_addr[p*5 +: 5] !== e.addr[p]) begin
          errors++;
          $display("FAIL %s rd_addr[%0d]: got %0d want %0d",
                   e.name, p, rd_addr[p*5 +: 5], e.addr[p]);
        end
        checks++;
        if (rd_data[p*XW +: XW] !== e.data[p]) begin
          errors++;
          $display("FAIL %s rd_data[%0d]: got %h want %h",
                   e.name, p, rd_data[p*XW +: XW], e.data[p]);
        end
      end
    end
  endtask

  // One cycle: check outputs owed from the previous cycle, drive this
  // cycle's inputs, check the combinational ack, queue next cycle's outputs.
  task automatic step(input vec_t v, input string name);
    out_t e;
    @(posedge clk);
    #1;
    check_out();
    rst        = v.rst;
    unit_valid = v.valid;
    unit_rd    = v.rd;
    for (int u = 0; u < N; u++) begin
      unit_data[u*XW +: XW] = mkdata(v.rd[u], u);
    end
    #1;
    checks++;
    if (unit_ack !== v.ack) begin
      errors++;
      $display("FAIL %s unit_ack: got %b want %b", name, unit_ack, v.ack);
    end
    e.ret     = v.rst ? 2'b00 : v.ret;
    e.wb      = v.rst ? 4'b0000 : v.wb;
    e.chk_all = v.rst;
    e.name    = name;
    for (int p = 0; p < W; p++) begin
      e.addr[p] = v.rst ? 5'd0 : v.addr[p];
      e.data[p] = v.rst ? 32'd0 : mkdata(v.addr[p], int'(v.src[p]));
    end
    exp_q.push_back(e);
    $display("%-8s rst=%b valid=%b ack=%b exp_ack=%b", name, v.rst, v.valid, unit_ack, v.ack);
  endtask

  initial begin
    vec_t v;
    rst        = 1'b1;
    unit_valid = '0;
    unit_rd    = '0;
    unit_data  = '0;

    //                valid r3  r2  r1  r0  ack      ret    a1  a0  s1 s0  wb
    table_v[0]  = mk(4'hF,  8,  7,  6,  5, 4'b0011, 2'b11,  6,  5, 1, 0, 4'b0010);
    table_v[1]  = mk(4'hC,  8,  7,  0,  0, 4'b1100, 2'b11,  8,  7, 3, 2, 4'b1010);
    table_v[2]  = mk(4'h3,  0,  0,  9,  9, 4'b0001, 2'b01,  0,  9, 0, 0, 4'b1010);
    table_v[3]  = mk(4'h2,  0,  0,  9,  0, 4'b0010, 2'b01,  0,  9, 0, 1, 4'b1000);
    table_v[4]  = mk(4'hC, 21, 20,  0,  0, 4'b1100, 2'b11, 21, 20, 3, 2, 4'b1000);
    table_v[5]  = mk(4'h7,  0,  4,  3,  0, 4'b0111, 2'b11,  4,  3, 2, 1, 4'b1100);
    table_v[6]  = mk(4'h8, 22,  0,  0,  0, 4'b1000, 2'b01,  0, 22, 0, 3, 4'b0100);
    table_v[7]  = mk(4'hF, 10, 10, 10, 10, 4'b0001, 2'b01,  0, 10, 0, 0, 4'b0100);
    table_v[8]  = mk(4'hF, 10, 10, 10, 10, 4'b0010, 2'b01,  0, 10, 0, 1, 4'b0100);
    table_v[9]  = mk(4'hF, 10, 10, 10, 10, 4'b0100, 2'b01,  0, 10, 0, 2, 4'b0000);
    table_v[10] = mk(4'hF, 10, 10, 10, 10, 4'b1000, 2'b01,  0, 10, 0, 3, 4'b0000);
    table_v[11] = mk(4'hF, 10, 10, 10, 10, 4'b0001, 2'b01,  0, 10, 0, 0, 4'b0000);
    table_v[12] = mk(4'hF, 14, 13, 12, 11, 4'b0110, 2'b11, 13, 12, 2, 1, 4'b0100);
    table_v[13] = mk(4'h0,  0,  0,  0,  0, 4'b0000, 2'b00,  0,  0, 0, 0, 4'b0100);
    table_v[14] = mk(4'h9, 15,  0,  0, 15, 4'b1000, 2'b01,  0, 15, 0, 3, 4'b0100);
    table_v[15] = mk(4'hF,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 0, 0, 4'b0100);

    // Reset held three cycles with every unit requesting.
    v = mk(4'hF, 4, 3, 2, 1, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000);
    v.rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(v, $sformatf("reset%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      step(table_v[i], $sformatf("vec%0d", i));
    end

    // Reset arriving while units 1,2 would be granted: drop, then regrant
    // from pointer 0 once released.
    step(mk(4'h4, 0, 31 - 1 + 10, 0, 0, 4'b0100, 2'b01, 0, 40, 0, 2, 4'b0000), "pre_rst");
    v = mk(4'h6, 0, 31, 30, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000);
    v.rst = 1'b1;
    step(v, "mid_rst");
    step(mk(4'h6, 0, 31, 30, 0, 4'b0110, 2'b11, 31, 30, 2, 1, 4'b0100), "post_rst");
    step(mk(4'h0, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0100), "flush");

    @(posedge clk);
    #1;
    check_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
